// File: rtl/seg7_multidigit_ctrl.sv
// Registered multi-digit 7-segment controller for direct-drive HEX displays.
// Hex or decimal display; decimal mode uses a sequential double-dabble converter.
module seg7_multidigit_ctrl #(
    parameter int NDIG      = 4,
    parameter bit BLANK_DEF = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*NDIG-1:0]   value,
    input  logic                mode_dec,
    input  logic                blank_en,
    output logic                busy,
    output logic                overflow,
    output logic [7*NDIG-1:0]   seg
);

    localparam int W    = 4 * NDIG;
    localparam int NBCD = NDIG + NDIG / 4 + 1;
    localparam int BW   = 4 * NBCD;
    localparam int CW   = $clog2(W + 1);

    localparam logic [CW-1:0]     CNT_INIT = CW'(W);
    localparam logic [7*NDIG-1:0] SEG_RST  = {{(NDIG-1){7'h7F}}, 7'h40};

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t            state;
    logic [W-1:0]      val_q;
    logic              mode_q;
    logic              blank_q;
    logic [BW-1:0]     bcd;
    logic [W-1:0]      shreg;
    logic [CW-1:0]     cnt;

    logic [BW-1:0]     bcd_adj;
    logic [3:0]        nib [NDIG];
    logic              ovf_next;
    logic              lead_zero;
    logic [7*NDIG-1:0] seg_next;

    // Active-low {g,f,e,d,c,b,a} glyphs for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < NBCD; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        for (int i = 0; i < NDIG; i++)
            nib[i] = mode_q ? bcd[4*i +: 4] : val_q[4*i +: 4];
    end

    // Any non-zero BCD digit above the displayed ones means the value does not fit.
    always_comb ovf_next = mode_q && (|bcd[BW-1:W]);

    always_comb begin
        seg_next  = '0;
        lead_zero = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (nib[i] == 4'd0);
            if (ovf_next)
                seg_next[7*i +: 7] = 7'h3F;
            else if (blank_q && lead_zero && (i != 0))
                seg_next[7*i +: 7] = 7'h7F;
            else
                seg_next[7*i +: 7] = hex7(nib[i]);
        end
    end

    // NOTE: sequential state uses <= so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            overflow <= 1'b0;
            blank_q  <= BLANK_DEF;
            seg      <= SEG_RST;
            val_q    <= '0;
            mode_q   <= 1'b0;
            bcd      <= '0;
            shreg    <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        val_q   <= value;
                        mode_q  <= mode_dec;
                        blank_q <= blank_en;
                        busy    <= 1'b1;
                        if (mode_dec) begin
                            bcd   <= '0;
                            shreg <= value;
                            cnt   <= CNT_INIT;
                            state <= CONV;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                CONV: begin
                    bcd   <= {bcd_adj[BW-2:0], shreg[W-1]};
                    shreg <= {shreg[W-2:0], 1'b0};
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= DONE;
                end
                DONE: begin
                    seg      <= seg_next;
                    overflow <= ovf_next;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_multidigit_ctrl.sv
// Self-checking bench for seg7_multidigit_ctrl: vector table with a scoreboard,
// plus hand-written handshake, abort and 6-digit sequences.
module tb_seg7_multidigit_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        load4, mode4, blank4;
    logic [15:0] value4;
    logic        busy4, ovf4;
    logic [27:0] seg4;

    logic        load6, mode6, blank6;
    logic [23:0] value6;
    logic        busy6, ovf6;
    logic [41:0] seg6;

    seg7_multidigit_ctrl #(.NDIG(4), .BLANK_DEF(1'b1)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load4),
        .value    (value4),
        .mode_dec (mode4),
        .blank_en (blank4),
        .busy     (busy4),
        .overflow (ovf4),
        .seg      (seg4)
    );

    seg7_multidigit_ctrl #(.NDIG(6), .BLANK_DEF(1'b1)) dut6 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load6),
        .value    (value6),
        .mode_dec (mode6),
        .blank_en (blank6),
        .busy     (busy6),
        .overflow (ovf6),
        .seg      (seg6)
    );

    typedef struct {
        logic [15:0] value;
        logic        mode_dec;
        logic        blank_en;
        logic [27:0] seg;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [27:0] seg;
        logic        ovf;
        int          lat;
    } exp_t;

    localparam logic [27:0] RST4 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [41:0] RST6 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};

    vec_t vecs [12];
    exp_t sb [$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Drive one load on dut4, then follow busy until it falls and score the result.
    task automatic run_vec(input vec_t v, input string name);
        logic [27:0] prev;
        logic        held;
        int          n;
        exp_t        e;
        @(negedge clk);
        value4 = v.value;
        mode4  = v.mode_dec;
        blank4 = v.blank_en;
        load4  = 1'b1;
        sb.push_back('{seg: v.seg, ovf: v.ovf, lat: v.mode_dec ? 17 : 1});
        prev = seg4;
        @(posedge clk);
        #1;
        load4 = 1'b0;
        check({name, "_busy_rise"}, 64'(busy4), 64'(1));
        held = 1'b1;
        n    = 0;
        while (busy4 && n < 100) begin
            if (seg4 !== prev) held = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        check({name, "_latency"}, 64'(n), 64'(e.lat));
        check({name, "_hold"}, 64'(held), 64'(1));
        check({name, "_seg"}, 64'(seg4), 64'(e.seg));
        check({name, "_ovf"}, 64'(ovf4), 64'(e.ovf));
    endtask

    task automatic run6(input logic [23:0] v, input logic [41:0] exp_seg,
                        input logic exp_ovf, input string name);
        int n;
        @(negedge clk);
        value6 = v;
        mode6  = 1'b1;
        blank6 = 1'b1;
        load6  = 1'b1;
        @(posedge clk);
        #1;
        load6 = 1'b0;
        n = 0;
        while (busy6 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(25));
        check({name, "_seg"}, 64'(seg6), 64'(exp_seg));
        check({name, "_ovf"}, 64'(ovf6), 64'(exp_ovf));
    endtask

    initial begin
        int n;

        vecs[0]  = '{16'h00A5, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h08, 7'h12}, 1'b0};
        vecs[1]  = '{16'h00A5, 1'b0, 1'b0, {7'h40, 7'h40, 7'h08, 7'h12}, 1'b0};
        vecs[2]  = '{16'd1234, 1'b1, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0};
        vecs[3]  = '{16'd0,    1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0};
        vecs[4]  = '{16'd10000, 1'b1, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
        vecs[5]  = '{16'd9999, 1'b1, 1'b1, {7'h10, 7'h10, 7'h10, 7'h10}, 1'b0};
        vecs[6]  = '{16'hBEEF, 1'b0, 1'b1, {7'h03, 7'h06, 7'h06, 7'h0E}, 1'b0};
        vecs[7]  = '{16'h0000, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
        vecs[8]  = '{16'd256,  1'b1, 1'b1, {7'h7F, 7'h24, 7'h12, 7'h02}, 1'b0};
        vecs[9]  = '{16'd65535, 1'b1, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
        vecs[10] = '{16'h0F00, 1'b0, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h40}, 1'b0};
        vecs[11] = '{16'd7,    1'b1, 1'b0, {7'h40, 7'h40, 7'h40, 7'h78}, 1'b0};

        rst_n  = 1'b0;
        load4  = 1'b0; mode4 = 1'b0; blank4 = 1'b0; value4 = '0;
        load6  = 1'b0; mode6 = 1'b0; blank6 = 1'b0; value6 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_seg4", 64'(seg4), 64'(RST4));
        check("rst_busy4", 64'(busy4), 64'(0));
        check("rst_ovf4", 64'(ovf4), 64'(0));
        check("rst_seg6", 64'(seg6), 64'(RST6));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // A load during CONV must be dropped; the first conversion completes untouched.
        @(negedge clk);
        value4 = 16'd1234; mode4 = 1'b1; blank4 = 1'b1; load4 = 1'b1;
        @(posedge clk);
        #1;
        load4 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        value4 = 16'd42; mode4 = 1'b0; load4 = 1'b1;
        @(posedge clk);
        #1;
        load4 = 1'b0;
        n = 5;
        while (busy4 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drop_latency", 64'(n), 64'(17));
        check("drop_seg", 64'(seg4), 64'({7'h79, 7'h24, 7'h30, 7'h19}));
        @(posedge clk);
        #1;
        check("drop_not_queued", 64'(busy4), 64'(0));

        // Abort: reset during CONV cycle 8 of a decimal load, after an overflow result.
        run_vec('{16'd10000, 1'b1, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1}, "pre_abort");
        @(negedge clk);
        value4 = 16'd1234; mode4 = 1'b1; blank4 = 1'b1; load4 = 1'b1;
        @(posedge clk);
        #1;
        load4 = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_seg", 64'(seg4), 64'(RST4));
        check("abort_busy", 64'(busy4), 64'(0));
        check("abort_ovf", 64'(ovf4), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_update", 64'(seg4), 64'(RST4));
        check("abort_idle", 64'(busy4), 64'(0));

        // Reset and load on the same edge: reset wins.
        @(negedge clk);
        rst_n = 1'b0; value4 = 16'h00A5; mode4 = 1'b0; load4 = 1'b1;
        @(posedge clk);
        #1;
        check("rst_load_busy", 64'(busy4), 64'(0));
        @(negedge clk);
        rst_n = 1'b1; load4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_load_seg", 64'(seg4), 64'(RST4));

        run6(24'hFFFFFF, {6{7'h3F}}, 1'b1, "d6_ovf");
        run6(24'd999999, {6{7'h10}}, 1'b0, "d6_max");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
